stopwatch_ctrl: RTL and testbench

Run/pause/clear/lap controller for the six-digit seven-segment timer. Debounces three front-panel keys, runs the IDLE/RUN/PAUSE state machine, and generates the prescaled tick. Maintains a 6-digit BCD count whose 24-bit output feeds the per-digit `convert` instances ahead of `digital_tube_display`. It replaces the free-running counter with a user-sequenced one.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/key_debounce.sv | 57 +++++
 rtl/stopwatch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: definitions shared by the stopwatch controller and its
// sub-modules.
//   state_t  : controller states (IDLE=0, RUN=1, PAUSE=2)
//   DIGITS   : number of BCD digits in the count
//   BCD_W    : width of one BCD digit
//   CNT_W    : width of the packed BCD count
//   BCD_MAX  : largest legal BCD digit value
package stopwatch_pkg;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned BCD_W  = 4;
  localparam int unsigned CNT_W  = DIGITS * BCD_W;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: front-panel key conditioner.
//   Raw active-low key -> 2-FF synchronizer -> stable-time debouncer ->
//   one-cycle press pulse on each debounced 1->0 transition.
// Parameters:
//   DEB_CYC : consecutive cycles the synchronized level must disagree with
//             the debounced level before the debounced level follows (>= 1)
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (key treated as released)
//   key_n : raw key, active low, asynchronous to clk
//   press : registered one-cycle pulse per debounced key press
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned     CNT_W_DEB = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W_DEB-1:0] STABLE_MAX = CNT_W_DEB'(DEB_CYC - 1);

  logic                 sync1;
  logic                 sync2;
  logic                 level;
  logic [CNT_W_DEB-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      level      <= 1'b1;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        // The DEB_CYC-th consecutive disagreeing cycle commits the new level.
        if (stable_cnt == STABLE_MAX) begin
          level      <= sync2;
          stable_cnt <= '0;
          press      <= ~sync2;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/lap controller for the six-digit BCD timer.
//   Debounces the front-panel keys, sequences IDLE/RUN/PAUSE, prescales the
//   clock into count ticks and maintains a 6-digit BCD count.
// Optional feature macro: STOPWATCH_LAP_EN (lap key, display freeze).
// Parameters:
//   CLK_HZ      : input clock frequency
//   TICK_HZ     : count rate; CLK_HZ/TICK_HZ must be an integer >= 2
//   DEBOUNCE_MS : key stable time in milliseconds
// Ports:
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   key_run_n  : raw run/pause key, active low
//   key_clr_n  : raw clear key, active low
//   key_lap_n  : raw lap key, active low (STOPWATCH_LAP_EN only)
//   cnt        : displayed BCD count, cnt[3:0] least significant digit
//   running    : high while in RUN
//   lap_active : high while the display is frozen
//   ovf        : one-cycle pulse when the count wraps 999999 -> 000000
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_run_n,
  input  logic             key_clr_n,
`ifdef STOPWATCH_LAP_EN
  input  logic             key_lap_n,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic             running,
  output logic             lap_active,
  output logic             ovf
);

  localparam int unsigned DEB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W   = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic press_run;
  logic press_clr;

  state_t             state;
  state_t             state_next;
  logic [PRE_W-1:0]   pre;
  logic [CNT_W-1:0]   cnt_int;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   cnt_int_next;
  logic               inc_carry;
  logic               tick;
  logic               run_ev;
  logic               clr_now;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_run (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_run_n),
    .press (press_run)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clr_n),
    .press (press_clr)
  );

  // A clr pulse masks a run pulse in the same cycle even when clr itself is
  // ignored (RUN).
  assign run_ev  = press_run & ~press_clr;
  assign clr_now = press_clr & (state != RUN);
  assign tick    = (state == RUN) && (pre == PRE_MAX);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (run_ev) state_next = RUN;
      RUN:     if (run_ev) state_next = PAUSE;
      PAUSE: begin
        if (press_clr)   state_next = IDLE;
        else if (run_ev) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit-wise BCD increment; any digit at or above 9 rolls to 0 with carry.
  always_comb begin
    cnt_inc   = cnt_int;
    inc_carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (cnt_int[i*BCD_W +: BCD_W] >= BCD_MAX) begin
          cnt_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          cnt_inc[i*BCD_W +: BCD_W] = cnt_int[i*BCD_W +: BCD_W] + 1'b1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_int_next = cnt_int;
    if (clr_now)   cnt_int_next = '0;
    else if (tick) cnt_int_next = cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre     <= '0;
      cnt_int <= '0;
      running <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      cnt_int <= cnt_int_next;
      ovf     <= tick & inc_carry;
      // Pausing leaves pre untouched so the fractional tick survives.
      if (clr_now || (state == IDLE && run_ev)) begin
        pre <= '0;
      end else if (state == RUN) begin
        pre <= tick ? '0 : pre + 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic press_lap;
  logic lap_ev;
  logic lap_next;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_lap_n),
    .press (press_lap)
  );

  assign lap_ev = press_lap & ~press_clr & ~press_run;

  always_comb begin
    lap_next = lap_active;
    if (clr_now) begin
      lap_next = 1'b0;
    end else if (lap_ev) begin
      if (lap_active)         lap_next = 1'b0;
      else if (state == RUN)  lap_next = 1'b1;
    end
  end

  // Display tracks the next internal count except while the freeze persists;
  // entering the freeze therefore captures the snapshot in the same write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      lap_active <= 1'b0;
    end else begin
      lap_active <= lap_next;
      if (!(lap_active && lap_next)) cnt <= cnt_int_next;
    end
  end
`else
  assign cnt        = cnt_int;
  assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed self-checking bench for stopwatch_ctrl with
// CLK_HZ=1000, TICK_HZ=100 (divide by 10), DEBOUNCE_MS=3 (3-cycle debounce).
// Lap checks are compiled in with STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_run_n;
  logic        key_clr_n;
`ifdef STOPWATCH_LAP_EN
  logic        key_lap_n;
`endif
  logic [23:0] cnt;
  logic        running;
  logic        lap_active;
  logic        ovf;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .DEBOUNCE_MS (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_run_n  (key_run_n),
    .key_clr_n  (key_clr_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n  (key_lap_n),
`endif
    .cnt        (cnt),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Bounded wait for running to reach the wanted level, sampled at negedges.
  task automatic wait_running(input string tag, input logic want);
    int unsigned n = 0;
    while (running !== want && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk1(tag, running, want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_run_n = 1'b1;
    key_clr_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    key_lap_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk24("reset_cnt", cnt, 24'h000000);
    chk1("reset_running", running, 1'b0);
    chk1("reset_lap", lap_active, 1'b0);
    chk1("reset_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two 2-cycle glitches must not produce a press.
    key_run_n = 1'b0; repeat (2) @(negedge clk);
    key_run_n = 1'b1; repeat (2) @(negedge clk);
    key_run_n = 1'b0; repeat (2) @(negedge clk);
    key_run_n = 1'b1; repeat (12) @(negedge clk);
    chk1("glitch_no_press", running, 1'b0);

    // A 10-cycle hold gives exactly one press (a second would pause).
    key_run_n = 1'b0; repeat (10) @(negedge clk);
    key_run_n = 1'b1; repeat (12) @(negedge clk);
    chk1("hold_one_press", running, 1'b1);

    rst_n = 1'b0;
    @(negedge clk);
    chk1("rst_after_deb_running", running, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run: count bumps every 10 cycles after running rises (E).
    key_run_n = 1'b0;
    wait_running("run_start", 1'b1);
    key_run_n = 1'b1;
    repeat (100) @(negedge clk);
    chk24("run_100", cnt, 24'h000010);
    repeat (150) @(negedge clk);
    chk24("run_250", cnt, 24'h000025);

    // Pause: press lands at E+255, PAUSE at E+256 with prescaler at 6.
    key_run_n = 1'b0;
    wait_running("pause", 1'b0);
    key_run_n = 1'b1;
    chk24("pause_cnt", cnt, 24'h000025);
    for (int i = 0; i < 5; i++) begin
      repeat (100) @(negedge clk);
      chk24("pause_hold", cnt, 24'h000025);
    end

    // Resume from held prescaler 6: first increment 4 cycles after running.
    key_run_n = 1'b0;
    wait_running("resume", 1'b1);
    key_run_n = 1'b1;
    repeat (3) @(negedge clk);
    chk24("resume_frac_before", cnt, 24'h000025);
    @(negedge clk);
    chk24("resume_frac_tick", cnt, 24'h000026);

    // Clear in RUN is ignored.
    key_clr_n = 1'b0; repeat (8) @(negedge clk);
    key_clr_n = 1'b1; repeat (8) @(negedge clk);
    chk1("clr_in_run_running", running, 1'b1);
    chk24("clr_in_run_cnt", cnt, 24'h000027);

    key_run_n = 1'b0;
    wait_running("pause2", 1'b0);
    key_run_n = 1'b1;
    chk24("pause2_cnt", cnt, 24'h000028);
    repeat (10) @(negedge clk);

    key_clr_n = 1'b0; repeat (8) @(negedge clk);
    key_clr_n = 1'b1; repeat (8) @(negedge clk);
    chk24("clr_in_pause_cnt", cnt, 24'h000000);
    chk1("clr_in_pause_running", running, 1'b0);

    // Fresh prescale after clear: first increment exactly 10 cycles in.
    key_run_n = 1'b0;
    wait_running("fresh_run", 1'b1);
    key_run_n = 1'b1;
    repeat (9) @(negedge clk);
    chk24("fresh_before_tick", cnt, 24'h000000);
    @(negedge clk);
    chk24("fresh_first_tick", cnt, 24'h000001);

    // Wrap: prescaler is 0 here, next ticks land 10 and 20 cycles on.
    force dut.cnt_int = 24'h999998;
    #1;
    release dut.cnt_int;
    repeat (9) @(negedge clk);
    chk24("wrap_pre", cnt, 24'h999998);
    @(negedge clk);
    chk24("wrap_999999", cnt, 24'h999999);
    chk1("wrap_no_ovf_yet", ovf, 1'b0);
    repeat (10) @(negedge clk);
    chk24("wrap_zero", cnt, 24'h000000);
    chk1("wrap_ovf", ovf, 1'b1);
    chk1("wrap_running", running, 1'b1);
    @(negedge clk);
    chk1("wrap_ovf_one_cycle", ovf, 1'b0);

    // Simultaneous run+clr from PAUSE: clr wins.
    repeat (19) @(negedge clk);
    key_run_n = 1'b0; repeat (8) @(negedge clk);
    key_run_n = 1'b1; repeat (8) @(negedge clk);
    chk24("simul_paused_cnt", cnt, 24'h000002);
    chk1("simul_paused", running, 1'b0);
    key_run_n = 1'b0; key_clr_n = 1'b0; repeat (8) @(negedge clk);
    key_run_n = 1'b1; key_clr_n = 1'b1; repeat (8) @(negedge clk);
    chk24("simul_cnt", cnt, 24'h000000);
    chk1("simul_running", running, 1'b0);

    key_run_n = 1'b0;
    wait_running("run3", 1'b1);
    key_run_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    // Lap press lands at E+124, freeze at E+125 with internal count 12.
    repeat (119) @(negedge clk);
    key_lap_n = 1'b0; repeat (8) @(negedge clk);
    key_lap_n = 1'b1;
    chk24("lap_freeze_cnt", cnt, 24'h000012);
    chk1("lap_freeze_active", lap_active, 1'b1);
    repeat (100) @(negedge clk);
    chk24("lap_frozen_hold", cnt, 24'h000012);
    key_lap_n = 1'b0; repeat (8) @(negedge clk);
    key_lap_n = 1'b1;
    chk24("lap_release_cnt", cnt, 24'h000023);
    chk1("lap_release_active", lap_active, 1'b0);
`else
    repeat (30) @(negedge clk);
    chk1("lap_tied_low", lap_active, 1'b0);
`endif

    // Reset mid-run and mid-debounce.
    key_run_n = 1'b0; repeat (3) @(negedge clk);
    rst_n = 1'b0; key_run_n = 1'b1;
    @(negedge clk);
    chk24("rst_run_cnt", cnt, 24'h000000);
    chk1("rst_run_running", running, 1'b0);
    chk1("rst_run_lap", lap_active, 1'b0);
    chk1("rst_run_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk1("rst_release_no_press", running, 1'b0);
    chk24("rst_release_cnt", cnt, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
